// File: rtl/sp_pkg.sv
// rtl/sp_pkg.sv - shared constants and request/response layouts for the scratchpad bank
package sp_pkg;
    localparam int NUM_MATS = 4;
    localparam int ROWS     = 4;
    localparam int ROW_W    = 64;
    localparam int ADDR_W   = 32;
    localparam int MT_W     = 2;
    localparam int MAT_S_W  = $clog2(NUM_MATS);
    localparam int ROW_S_W  = $clog2(ROWS);

    localparam logic [MT_W-1:0] MT_STORE = '0;

    typedef struct packed {
        logic               gemm_result;
        logic [MAT_S_W-1:0] mat_s;
        logic [ROW_S_W-1:0] row_s;
        logic [ROW_W-1:0]   data;
    } wreq_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [MT_W-1:0]    mat_t;
        logic [MAT_S_W-1:0] mat_s;
        logic [ROW_S_W-1:0] row_s;
    } rreq_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [MAT_S_W-1:0] mat_s;
        logic [ROW_S_W-1:0] row_s;
        logic [ROW_W-1:0]   data;
    } dram_resp_t;

    typedef struct packed {
        logic [MT_W-1:0]    mat_t;
        logic [MAT_S_W-1:0] mat_s;
        logic [ROW_S_W-1:0] row_s;
        logic [ROW_W-1:0]   data;
    } gemm_resp_t;
endpackage

// File: rtl/sp_sync_fifo.sv
// rtl/sp_sync_fifo.sv - synchronous FIFO with occupancy count; DEPTH must be a power of 2
module sp_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    // A push into a full FIFO is accepted only when a pop frees the slot first.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/scratchpad_bank_pipe.sv
// rtl/scratchpad_bank_pipe.sv - scratchpad bank: queued row writes, credit-gated 1-cycle read pipe, completion tracking
module scratchpad_bank_pipe #(
    parameter int NUM_MATS = sp_pkg::NUM_MATS,
    parameter int ROWS     = sp_pkg::ROWS,
    parameter int ROW_W    = sp_pkg::ROW_W,
    parameter int ADDR_W   = sp_pkg::ADDR_W,
    parameter int MT_W     = sp_pkg::MT_W,
    parameter int WQ_DEPTH = 8,
    parameter int RQ_DEPTH = 8,
    parameter int OQ_DEPTH = 8,
    localparam int MS = $clog2(NUM_MATS),
    localparam int RS = $clog2(ROWS)
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        wq_wen,
    input  logic [1+MS+RS+ROW_W-1:0]    wq_wdata,
    output logic                        wq_full,
    input  logic                        rq_wen,
    input  logic [ADDR_W+MT_W+MS+RS-1:0] rq_wdata,
    output logic                        rq_full,
    input  logic                        dram_ren,
    output logic [ADDR_W+MS+RS+ROW_W-1:0] dram_rdata,
    output logic                        dram_empty,
    input  logic                        gemm_ren,
    output logic [MT_W+MS+RS+ROW_W-1:0] gemm_rdata,
    output logic                        gemm_empty,
    input  logic                        mat_release,
    input  logic [MS-1:0]               mat_release_sel,
    output logic                        load_complete,
    output logic [MS-1:0]               load_mat,
    output logic                        gemm_complete,
    output logic [MS-1:0]               gemm_mat,
    output logic [NUM_MATS-1:0]         mat_ready
);
    import sp_pkg::*;

    localparam int WQ_W = 1 + MS + RS + ROW_W;
    localparam int RQ_W = ADDR_W + MT_W + MS + RS;
    localparam int OCW  = $clog2(OQ_DEPTH + 1);

    logic                             wq_empty, rq_empty, rq_pop, dram_full, gemm_full;
    logic [WQ_W-1:0]                  wq_head;
    logic [RQ_W-1:0]                  rq_head;
    logic [$clog2(WQ_DEPTH+1)-1:0]    wq_count;
    logic [$clog2(RQ_DEPTH+1)-1:0]    rq_count;
    logic [OCW-1:0]                   dram_count, gemm_count;

    logic                             w_en, w_res;
    logic [MS-1:0]                    w_mat, r_mat;
    logic [RS-1:0]                    w_row, r_row;
    logic [ROW_W-1:0]                 w_data, r_data;
    logic [ADDR_W-1:0]                r_addr;
    logic [MT_W-1:0]                  r_mt;
    logic                             r_dram;

    logic [ROW_W-1:0]                 array_q [NUM_MATS][ROWS];
    logic [NUM_MATS-1:0][ROWS-1:0]    valid_q, valid_nxt;
    logic [NUM_MATS-1:0]              is_result_q, res_nxt;
    logic                             ld_pulse, gm_pulse;
    logic [MS-1:0]                    ld_idx, gm_idx;

    logic                             s1_valid, s1_dram;
    logic [ADDR_W-1:0]                s1_addr;
    logic [MT_W-1:0]                  s1_mt;
    logic [MS-1:0]                    s1_mat;
    logic [RS-1:0]                    s1_row;
    logic [ROW_W-1:0]                 s1_data;
    logic [OCW:0]                     dram_need, gemm_need;
    logic                             unused_flags;

    sp_sync_fifo #(.WIDTH(WQ_W), .DEPTH(WQ_DEPTH)) u_wq (
        .clk(CLK), .rst(RST), .push(wq_wen), .push_data(wq_wdata), .pop(w_en),
        .pop_data(wq_head), .full(wq_full), .empty(wq_empty), .count(wq_count));

    sp_sync_fifo #(.WIDTH(RQ_W), .DEPTH(RQ_DEPTH)) u_rq (
        .clk(CLK), .rst(RST), .push(rq_wen), .push_data(rq_wdata), .pop(rq_pop),
        .pop_data(rq_head), .full(rq_full), .empty(rq_empty), .count(rq_count));

    sp_sync_fifo #(.WIDTH(ADDR_W+MS+RS+ROW_W), .DEPTH(OQ_DEPTH)) u_dram_oq (
        .clk(CLK), .rst(RST), .push(s1_valid && s1_dram),
        .push_data({s1_addr, s1_mat, s1_row, s1_data}), .pop(dram_ren),
        .pop_data(dram_rdata), .full(dram_full), .empty(dram_empty), .count(dram_count));

    sp_sync_fifo #(.WIDTH(MT_W+MS+RS+ROW_W), .DEPTH(OQ_DEPTH)) u_gemm_oq (
        .clk(CLK), .rst(RST), .push(s1_valid && !s1_dram),
        .push_data({s1_mt, s1_mat, s1_row, s1_data}), .pop(gemm_ren),
        .pop_data(gemm_rdata), .full(gemm_full), .empty(gemm_empty), .count(gemm_count));

    assign unused_flags = ^{wq_count, rq_count, dram_full, gemm_full};

    assign w_en = !wq_empty;
    assign {w_res, w_mat, w_row, w_data} = wq_head;
    assign {r_addr, r_mt, r_mat, r_row} = rq_head;
    assign r_dram = (r_mt == MT_W'(MT_STORE));

    // The entry sitting in stage 1 already owns a slot in its output queue.
    assign dram_need = {1'b0, dram_count} + (OCW+1)'(s1_valid && s1_dram);
    assign gemm_need = {1'b0, gemm_count} + (OCW+1)'(s1_valid && !s1_dram);
    assign rq_pop = !rq_empty &&
                    (r_dram ? (dram_need < (OCW+1)'(OQ_DEPTH)) : (gemm_need < (OCW+1)'(OQ_DEPTH)));
    assign r_data = (w_en && w_mat == r_mat && w_row == r_row) ? w_data : array_q[r_mat][r_row];

    always_comb begin
        valid_nxt = valid_q;
        res_nxt   = is_result_q;
        mat_ready = '0;
        ld_pulse  = 1'b0;
        gm_pulse  = 1'b0;
        ld_idx    = '0;
        gm_idx    = '0;
        for (int m = 0; m < NUM_MATS; m++) begin
            mat_ready[m] = &valid_q[m];
            // Release clears first so a same-cycle write to the matrix survives.
            if (mat_release && mat_release_sel == MS'(m)) valid_nxt[m] = '0;
            if (w_en && w_mat == MS'(m)) begin
                valid_nxt[m][w_row] = 1'b1;
                res_nxt[m]          = w_res;
            end
            if (!mat_ready[m] && (&valid_nxt[m])) begin
                if (res_nxt[m]) begin
                    gm_pulse = 1'b1;
                    gm_idx   = MS'(m);
                end else begin
                    ld_pulse = 1'b1;
                    ld_idx   = MS'(m);
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int m = 0; m < NUM_MATS; m++)
                for (int r = 0; r < ROWS; r++)
                    array_q[m][r] <= '0;
            valid_q       <= '0;
            is_result_q   <= '0;
            load_complete <= 1'b0;
            load_mat      <= '0;
            gemm_complete <= 1'b0;
            gemm_mat      <= '0;
            s1_valid      <= 1'b0;
            s1_dram       <= 1'b0;
            s1_addr       <= '0;
            s1_mt         <= '0;
            s1_mat        <= '0;
            s1_row        <= '0;
            s1_data       <= '0;
        end else begin
            if (w_en) array_q[w_mat][w_row] <= w_data;
            valid_q       <= valid_nxt;
            is_result_q   <= res_nxt;
            load_complete <= ld_pulse;
            load_mat      <= ld_idx;
            gemm_complete <= gm_pulse;
            gemm_mat      <= gm_idx;
            s1_valid      <= rq_pop;
            if (rq_pop) begin
                s1_dram <= r_dram;
                s1_addr <= r_addr;
                s1_mt   <= r_mt;
                s1_mat  <= r_mat;
                s1_row  <= r_row;
                s1_data <= r_data;
            end
        end
    end

`ifndef SYNTHESIS
    a_wq_overflow:  assert property (@(posedge CLK) disable iff (RST) !(wq_wen && wq_full));
    a_rq_overflow:  assert property (@(posedge CLK) disable iff (RST) !(rq_wen && rq_full));
    a_dram_under:   assert property (@(posedge CLK) disable iff (RST) !(dram_ren && dram_empty));
    a_gemm_under:   assert property (@(posedge CLK) disable iff (RST) !(gemm_ren && gemm_empty));
`endif
endmodule

// File: tb/tb_scratchpad_bank_pipe.sv
// tb/tb_scratchpad_bank_pipe.sv - scoreboard bench for scratchpad_bank_pipe
module tb_scratchpad_bank_pipe;
    import sp_pkg::*;

    logic        CLK;
    logic        RST;
    logic        wq_wen;
    wreq_t       wq_wdata;
    logic        wq_full;
    logic        rq_wen;
    rreq_t       rq_wdata;
    logic        rq_full;
    logic        dram_ren;
    dram_resp_t  dram_rdata;
    logic        dram_empty;
    logic        gemm_ren;
    gemm_resp_t  gemm_rdata;
    logic        gemm_empty;
    logic        mat_release;
    logic [1:0]  mat_release_sel;
    logic        load_complete;
    logic [1:0]  load_mat;
    logic        gemm_complete;
    logic [1:0]  gemm_mat;
    logic [3:0]  mat_ready;

    scratchpad_bank_pipe dut (
        .CLK(CLK), .RST(RST),
        .wq_wen(wq_wen), .wq_wdata(wq_wdata), .wq_full(wq_full),
        .rq_wen(rq_wen), .rq_wdata(rq_wdata), .rq_full(rq_full),
        .dram_ren(dram_ren), .dram_rdata(dram_rdata), .dram_empty(dram_empty),
        .gemm_ren(gemm_ren), .gemm_rdata(gemm_rdata), .gemm_empty(gemm_empty),
        .mat_release(mat_release), .mat_release_sel(mat_release_sel),
        .load_complete(load_complete), .load_mat(load_mat),
        .gemm_complete(gemm_complete), .gemm_mat(gemm_mat),
        .mat_ready(mat_ready));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    logic dram_pop_en = 1'b1;
    logic gemm_pop_en = 1'b1;
    dram_resp_t exp_dram[$];
    gemm_resp_t exp_gemm[$];
    logic [2:0] exp_cmp[$];   // {is_gemm, mat}
    int ord[4] = '{3, 1, 0, 2};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic wreq_t mk_w(input logic res, input int m, input int r, input logic [63:0] d);
        wreq_t w;
        w.gemm_result = res;
        w.mat_s = MAT_S_W'(m);
        w.row_s = ROW_S_W'(r);
        w.data  = d;
        return w;
    endfunction

    function automatic rreq_t mk_r(input logic [31:0] a, input int mt, input int m, input int r);
        rreq_t q;
        q.addr  = a;
        q.mat_t = MT_W'(mt);
        q.mat_s = MAT_S_W'(m);
        q.row_s = ROW_S_W'(r);
        return q;
    endfunction

    function automatic gemm_resp_t mk_g(input int mt, input int m, input int r, input logic [63:0] d);
        gemm_resp_t g;
        g.mat_t = MT_W'(mt);
        g.mat_s = MAT_S_W'(m);
        g.row_s = ROW_S_W'(r);
        g.data  = d;
        return g;
    endfunction

    // Monitor: compares whatever the DUT presents against the scoreboard queues.
    initial begin
        dram_ren = 1'b0;
        gemm_ren = 1'b0;
        forever begin
            @(negedge CLK);
            dram_ren = 1'b0;
            gemm_ren = 1'b0;
            if (!RST) begin
                if (dram_pop_en && !dram_empty) begin
                    if (exp_dram.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL dram_unexpected: got %0h expected none", dram_rdata);
                    end else check("dram_rdata", 128'(dram_rdata), 128'(exp_dram.pop_front()));
                    dram_ren = 1'b1;
                end
                if (gemm_pop_en && !gemm_empty) begin
                    if (exp_gemm.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL gemm_unexpected: got %0h expected none", gemm_rdata);
                    end else check("gemm_rdata", 128'(gemm_rdata), 128'(exp_gemm.pop_front()));
                    gemm_ren = 1'b1;
                end
                if (load_complete || gemm_complete) begin
                    if (exp_cmp.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL cmp_unexpected: got %0b%0b/%0d%0d expected none",
                                 load_complete, gemm_complete, load_mat, gemm_mat);
                    end else if (gemm_complete)
                        check("gemm_complete", 128'({1'b1, gemm_mat}), 128'(exp_cmp.pop_front()));
                    else
                        check("load_complete", 128'({1'b0, load_mat}), 128'(exp_cmp.pop_front()));
                end
            end
        end
    end

    initial begin
        RST = 1'b1;
        wq_wen = 1'b0; wq_wdata = '0;
        rq_wen = 1'b0; rq_wdata = '0;
        mat_release = 1'b0; mat_release_sel = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_wq_full", 128'(wq_full), 128'(0));
        check("rst_rq_full", 128'(rq_full), 128'(0));
        check("rst_dram_empty", 128'(dram_empty), 128'(1));
        check("rst_gemm_empty", 128'(gemm_empty), 128'(1));
        check("rst_cmp", 128'({load_complete, gemm_complete, load_mat, gemm_mat}), 128'(0));
        check("rst_mat_ready", 128'(mat_ready), 128'(0));
        check("rst_rdata", 128'({dram_rdata, gemm_rdata}), 128'(0));
        RST = 1'b0;
        tick();

        // Load mat 2 out of order; one load pulse after the final row
        for (int i = 0; i < 4; i++) begin
            wq_wen = 1'b1;
            wq_wdata = mk_w(1'b0, 2, ord[i], 64'h2200 + 64'(ord[i]));
            if (i == 3) exp_cmp.push_back(3'b0_10);
            tick();
        end
        wq_wen = 1'b0;
        @(negedge CLK);
        check("load_not_early", 128'(load_complete), 128'(0));
        @(negedge CLK);
        check("load_pulse", 128'({load_complete, load_mat}), 128'({1'b1, 2'd2}));
        @(negedge CLK);
        check("ready_mat2", 128'(mat_ready), 128'(4'b0100));
        tick();

        // DRAM store read with 2-edge latency after the rq pop
        wq_wen = 1'b1; wq_wdata = mk_w(1'b0, 1, 0, 64'hDEAD_BEEF);
        tick();
        wq_wen = 1'b0;
        rq_wen = 1'b1; rq_wdata = mk_r(32'h1000, 0, 1, 0);
        exp_dram.push_back({32'h1000, 2'd1, 2'd0, 64'hDEAD_BEEF});
        tick();
        rq_wen = 1'b0;
        @(negedge CLK);
        check("dram_lat_c0", 128'(dram_empty), 128'(1));
        @(negedge CLK);
        check("dram_lat_c1", 128'(dram_empty), 128'(1));
        @(negedge CLK);
        check("dram_lat_c2", 128'(dram_empty), 128'(0));
        tick();

        // Same-cycle write and read of mat 0 row 3: bypass
        wq_wen = 1'b1; wq_wdata = mk_w(1'b0, 0, 3, 64'hA5A5);
        rq_wen = 1'b1; rq_wdata = mk_r(32'h0, 2, 0, 3);
        exp_gemm.push_back(mk_g(2, 0, 3, 64'hA5A5));
        tick();
        wq_wen = 1'b0; rq_wen = 1'b0;
        repeat (6) tick();

        // GEMM backpressure: 8 fit in the output queue, 2 stay in rq
        gemm_pop_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rq_wen = 1'b1; rq_wdata = mk_r(32'h0, 1, 2, i % 4);
            exp_gemm.push_back(mk_g(1, 2, i % 4, 64'h2200 + 64'(i % 4)));
            tick();
        end
        rq_wen = 1'b0;
        repeat (6) tick();
        for (int i = 0; i < 5; i++) begin
            rq_wen = 1'b1; rq_wdata = mk_r(32'h0, 1, 2, i % 4);
            exp_gemm.push_back(mk_g(1, 2, i % 4, 64'h2200 + 64'(i % 4)));
            tick();
        end
        rq_wen = 1'b0;
        @(negedge CLK);
        check("rq_holds_7", 128'(rq_full), 128'(0));
        tick();
        rq_wen = 1'b1; rq_wdata = mk_r(32'h0, 1, 2, 1);
        exp_gemm.push_back(mk_g(1, 2, 1, 64'h2201));
        tick();
        rq_wen = 1'b0;
        @(negedge CLK);
        check("rq_holds_8", 128'(rq_full), 128'(1));
        check("gemm_oq_full", 128'(gemm_empty), 128'(0));
        tick();
        gemm_pop_en = 1'b1;
        for (int c = 0; c < 200 && exp_gemm.size() != 0; c++) tick();
        check("gemm_drained", 128'(exp_gemm.size()), 128'(0));

        // GEMM result matrix 3, then release with a concurrent rewrite of row 1
        for (int r = 0; r < 4; r++) begin
            wq_wen = 1'b1; wq_wdata = mk_w(1'b1, 3, r, 64'h3300 + 64'(r));
            if (r == 3) exp_cmp.push_back(3'b1_11);
            tick();
        end
        wq_wen = 1'b0;
        repeat (3) tick();
        check("ready_mat3", 128'(mat_ready), 128'(4'b1100));
        wq_wen = 1'b1; wq_wdata = mk_w(1'b1, 3, 1, 64'h3311);
        tick();
        wq_wen = 1'b0;
        mat_release = 1'b1; mat_release_sel = 2'd3;
        tick();
        mat_release = 1'b0;
        @(negedge CLK);
        check("release_mat3", 128'(mat_ready), 128'(4'b0100));
        tick();
        for (int i = 0; i < 2; i++) begin
            wq_wen = 1'b1; wq_wdata = mk_w(1'b1, 3, i * 2, 64'h3320);
            tick();
        end
        wq_wen = 1'b0;
        repeat (3) tick();
        check("mat3_partial", 128'(mat_ready), 128'(4'b0100));
        wq_wen = 1'b1; wq_wdata = mk_w(1'b1, 3, 3, 64'h3333);
        exp_cmp.push_back(3'b1_11);
        tick();
        wq_wen = 1'b0;
        repeat (3) tick();
        check("mat3_refilled", 128'(mat_ready), 128'(4'b1100));

        // Mid-operation reset with a full DRAM queue and 5 reads waiting
        dram_pop_en = 1'b0;
        for (int i = 0; i < 13; i++) begin
            rq_wen = 1'b1; rq_wdata = mk_r(32'h2000, 0, 2, 0);
            tick();
        end
        rq_wen = 1'b0;
        repeat (5) tick();
        @(negedge CLK);
        check("pre_rst_dram", 128'(dram_empty), 128'(0));
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        @(negedge CLK);
        check("post_rst_empty", 128'({dram_empty, gemm_empty}), 128'(2'b11));
        check("post_rst_ready", 128'(mat_ready), 128'(0));
        check("post_rst_full", 128'({wq_full, rq_full}), 128'(0));
        tick();
        dram_pop_en = 1'b1;
        repeat (10) tick();
        check("post_rst_silent", 128'({dram_empty, gemm_empty}), 128'(2'b11));
        check("sb_dram_left", 128'(exp_dram.size()), 128'(0));
        check("sb_cmp_left", 128'(exp_cmp.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/scratchpad_bank_pipe.md
Name: scratchpad_bank_pipe

Overview:
Parametrised scratchpad bank holding NUM_MATS matrices of ROWS rows of ROW_W bits, fed by a write-request queue and a read-request queue. Read responses are steered to a DRAM-store output queue or a GEMM-operand output queue through a registered 1-cycle read pipeline with credit-based backpressure. Per-matrix row-valid tracking produces load/GEMM completion pulses and a ready vector for the tensor-core scheduler. The block sits between the DRAM load/store unit and the systolic GEMM array, one instance per bank.

Parameters:
NUM_MATS, 4, matrices per bank (power of 2, >=2)
ROWS, 4, rows per matrix (power of 2, >=2)
ROW_W, 64, bits per row
ADDR_W, 32, DRAM address width
MT_W, 2, mat-type code width; code 0 = store to DRAM, nonzero = GEMM operand type
WQ_DEPTH, 8, write queue depth
RQ_DEPTH, 8, read queue depth
OQ_DEPTH, 8, depth of each output queue

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-high
wq_wen  in  1  push write request
wq_wdata  in  1+MS+RS+ROW_W  {gemm_result, mat_s, row_s, data}; MS=$clog2(NUM_MATS), RS=$clog2(ROWS)
wq_full  out  1  write queue full
rq_wen  in  1  push read request
rq_wdata  in  ADDR_W+MT_W+MS+RS  {addr, mat_t, mat_s, row_s}
rq_full  out  1  read queue full
dram_ren  in  1  pop DRAM output queue
dram_rdata  out  ADDR_W+MS+RS+ROW_W  {addr, mat_s, row_s, data}
dram_empty  out  1  DRAM output queue empty
gemm_ren  in  1  pop GEMM output queue
gemm_rdata  out  MT_W+MS+RS+ROW_W  {mat_t, mat_s, row_s, data}
gemm_empty  out  1  GEMM output queue empty
mat_release  in  1  clear row-valid bits of matrix mat_release_sel
mat_release_sel  in  MS  matrix to release
load_complete  out  1  1-cycle pulse: load matrix became fully valid
load_mat  out  MS  matrix index qualifying load_complete
gemm_complete  out  1  1-cycle pulse: GEMM result matrix became fully valid
gemm_mat  out  MS  matrix index qualifying gemm_complete
mat_ready  out  NUM_MATS  bit i = all ROWS rows of matrix i valid

Behaviour:
- Reset (RST high, async): array, valid bits, all queues and pipeline register cleared. Outputs: wq_full=0, rq_full=0, dram_empty=1, gemm_empty=1, load_complete=0, gemm_complete=0, load_mat=0, gemm_mat=0, mat_ready=0, rdata=0. Reset mid-operation discards in-flight requests without emitting responses.
- Write path: when wq is non-empty, pop the head every cycle and write data to array[mat_s][row_s] at the next edge; no stall condition. Set valid[mat_s][row_s]; a gemm_result row also sets a per-matrix is_result flag, and a load row clears it.
- Completion: when matrix m transitions from not-all-valid to all-valid, pulse load_complete/load_mat=m (is_result=0) or gemm_complete/gemm_mat=m (is_result=1) in the cycle after the completing write. A rewrite of an already-valid row never re-pulses. Row order is irrelevant.
- mat_release: clears valid[sel][*] and mat_ready[sel] at the next edge. A same-cycle write to the same matrix is applied after the clear, so that row stays valid.
- Read stage 0: pop the rq head iff rq is non-empty and the target queue (mat_t==0 -> DRAM, else GEMM) satisfies count + inflight_to_that_queue < OQ_DEPTH. Capture array row, metadata and destination into the stage-1 register at the edge.
- Read stage 1: push the registered entry into its output queue. Latency is rq pop to output-queue non-empty = 2 edges.
- Write/read same cycle, same mat/row: stage 1 captures the new write data (write-first bypass).
- A stalled rq head blocks later requests (in-order). There is no reordering between the DRAM and GEMM streams.
- Full queue push is ignored (no overrun corruption). Pop on empty is ignored. Simultaneous push+pop on a full output queue is legal and counts as a pop then push.
- Assertions: the wq_wen&&wq_full, rq_wen&&rq_full and ren&&empty cases must flag in simulation only.

Decomposition:
- Package sp_pkg: default constants (NUM_MATS, ROWS, ROW_W, ADDR_W, MT_W), MAT_S_W/ROW_S_W, packed typedefs wreq_t, rreq_t, dram_resp_t and gemm_resp_t for the default configuration, and MT_STORE='0.
- Sub-module sp_sync_fifo #(WIDTH, DEPTH): active-high async reset; full, empty and count outputs. Four instances: wq, rq, dram oq, gemm oq.

Test Plan:
- Write rows 0..3 of mat 2 (gemm_result=0) in order 3,1,0,2 -> single load_complete pulse with load_mat=2 one cycle after the row-2 write, and mat_ready=4'b0100.
- Write mat 1 row 0 = 64'hDEAD_BEEF, then read mat_t=0, addr=32'h1000 -> dram_rdata={32'h1000,1,0,64'hDEAD_BEEF} with dram_empty low 2 cycles after rq pop.
- Same-cycle write mat 0 row 3 = 64'hA5A5 and read mat 0 row 3 (mat_t=2) -> gemm_rdata.data = 64'hA5A5.
- Never pop the GEMM queue and issue 10 GEMM reads -> exactly 8 reach gemm oq, rq retains 2, and no entry is lost after gemm_ren resumes.
- Write 4 gemm_result rows to mat 3, then mat_release mat 3 concurrent with a rewrite of row 1 -> gemm_complete pulse with gemm_mat=3, then mat_ready[3]=0 and only valid[3][1] set.
- Assert RST for 1 cycle with 5 reads queued and a full DRAM queue -> all empty flags 1, mat_ready=0, no responses afterwards.
